// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle RISC-V control sequencer. Each instruction walks through
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WBACK] and this block drives the
//   shared datapath enables and mux selects for every step.
//
//   Parameter
//     MEM_WAIT  extra cycles a data-memory access occupies (0..15)
//
//   Ports
//     clk      in   rising-edge clock
//     rst      in   asynchronous active-high reset
//     OPCode   in   [6:0] opcode from IR, valid from the DECODE cycle on
//     Zero     in   ALU zero flag, used in EXEC for branches
//     PCWrite  out  PC load enable
//     PCsrc    out  0 = PC+4, 1 = PC+imm
//     IRWrite  out  instruction register load enable
//     EnW      out  register-file write enable
//     IMMSel   out  [1:0] 00 = I, 01 = S, 10 = B
//     ALUsrc   out  0 = rs2, 1 = immediate
//     RAMW     out  data-memory write strobe
//     RAMR     out  data-memory read enable
//     WB       out  write-back select, 0 = ALU, 1 = RAM
//     state    out  [2:0] current state code (debug)
//     trap     out  illegal opcode trapped
//
//   Build option
//     CTRL_ILLEGAL_TRAP_EN  unknown opcodes enter a sticky TRAP state;
//                           otherwise they retire as a NOP and trap is 0.
module multicycle_control #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] OPCode,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       PCsrc,
  output logic       IRWrite,
  output logic       EnW,
  output logic [1:0] IMMSel,
  output logic       ALUsrc,
  output logic       RAMW,
  output logic       RAMR,
  output logic       WB,
  output logic [2:0] state,
  output logic       trap
);

  localparam logic [2:0] st_fetch  = 3'd0;
  localparam logic [2:0] st_decode = 3'd1;
  localparam logic [2:0] st_exec   = 3'd2;
  localparam logic [2:0] st_mem    = 3'd3;
  localparam logic [2:0] st_wback  = 3'd4;
  localparam logic [2:0] st_trap   = 3'd7;

  localparam logic [6:0] op_r = 7'b0110011;
  localparam logic [6:0] op_i = 7'b0010011;
  localparam logic [6:0] op_s = 7'b0100011;
  localparam logic [6:0] op_l = 7'b0000011;
  localparam logic [6:0] op_b = 7'b1100011;

  localparam logic [3:0] mem_wait_c = 4'(MEM_WAIT);

  logic [2:0] state_q, state_d;
  logic [6:0] op_q;
  logic [3:0] cnt_q;

  logic is_r, is_i, is_s, is_l, is_b;
  logic live_known;
  logic mem_last;

  logic pcwrite_c, pcsrc_c, irwrite_c, enw_c, alusrc_c, ramw_c, ramr_c, wb_c, trap_c;
  logic [1:0] immsel_c;

  // Post-DECODE decisions use only the latched opcode.
  assign is_r = (op_q == op_r);
  assign is_i = (op_q == op_i);
  assign is_s = (op_q == op_s);
  assign is_l = (op_q == op_l);
  assign is_b = (op_q == op_b);

  assign live_known = (OPCode == op_r) || (OPCode == op_i) || (OPCode == op_s) ||
                      (OPCode == op_l) || (OPCode == op_b);

  assign mem_last = (cnt_q == mem_wait_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= st_fetch;
      op_q    <= 7'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (state_q == st_decode) begin
        op_q <= OPCode;
      end
      // Holding on the final MEM cycle keeps the counter from wrapping at 15.
      if (state_q == st_exec) begin
        cnt_q <= 4'd0;
      end else if (state_q == st_mem && !mem_last) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pcwrite_c = 1'b0;
    pcsrc_c   = 1'b0;
    irwrite_c = 1'b0;
    enw_c     = 1'b0;
    immsel_c  = 2'b00;
    alusrc_c  = 1'b0;
    ramw_c    = 1'b0;
    ramr_c    = 1'b0;
    wb_c      = 1'b0;
    trap_c    = 1'b0;
    case (state_q)
      st_fetch: begin
        irwrite_c = 1'b1;
        state_d   = st_decode;
      end
      st_decode: begin
        if (live_known) begin
          state_d = st_exec;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = st_trap;
`else
          // Unknown opcode retires as a NOP.
          pcwrite_c = 1'b1;
          state_d   = st_fetch;
`endif
        end
      end
      st_exec: begin
        alusrc_c = is_i | is_s | is_l;
        immsel_c = is_s ? 2'b01 : (is_b ? 2'b10 : 2'b00);
        if (is_r || is_i) begin
          state_d = st_wback;
        end else if (is_s || is_l) begin
          state_d = st_mem;
        end else begin
          pcwrite_c = is_b;
          pcsrc_c   = is_b & Zero;
          state_d   = st_fetch;
        end
      end
      st_mem: begin
        alusrc_c = 1'b1;
        immsel_c = is_s ? 2'b01 : 2'b00;
        ramr_c   = is_l;
        if (mem_last) begin
          if (is_s) begin
            ramw_c    = 1'b1;
            pcwrite_c = 1'b1;
            state_d   = st_fetch;
          end else begin
            state_d = st_wback;
          end
        end
      end
      st_wback: begin
        enw_c     = 1'b1;
        wb_c      = is_l;
        pcwrite_c = 1'b1;
        state_d   = st_fetch;
      end
      st_trap: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        trap_c  = 1'b1;
        state_d = st_trap;
`else
        state_d = st_fetch;
`endif
      end
      default: state_d = st_fetch;
    endcase
  end

  // Reset masks every output, including the Zero-driven PCsrc path.
  always_comb begin
    PCWrite = pcwrite_c & ~rst;
    PCsrc   = pcsrc_c & ~rst;
    IRWrite = irwrite_c & ~rst;
    EnW     = enw_c & ~rst;
    IMMSel  = rst ? 2'b00 : immsel_c;
    ALUsrc  = alusrc_c & ~rst;
    RAMW    = ramw_c & ~rst;
    RAMR    = ramr_c & ~rst;
    WB      = wb_c & ~rst;
    trap    = trap_c & ~rst;
    state   = state_q;
  end

endmodule
